// File: rtl/divider_mse_monitor_pkg.sv
`default_nettype none
// ============================================================================
// divider_mon_pkg : shared state encoding, default widths and saturating add
// Revision: 1.0
// ============================================================================
package divider_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_ACC  = 2'd2,
        ST_SKIP = 2'd3
    } state_t;

    localparam int NW_D    = 16;
    localparam int DW_D    = 8;
    localparam int ACC_W_D = 40;
    localparam int CNT_W_D = 24;

    // All-ones value of a w-bit unsigned quantity, w up to 64.
    function automatic logic [63:0] sat_mask(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, sat_mask(w)}) ? sat_mask(w) : s[63:0];
    endfunction

    function automatic logic sat_ovf(input logic [63:0] a, input logic [63:0] b,
                                     input int unsigned w);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s > {1'b0, sat_mask(w)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider_mse_monitor_if.sv
`default_nettype none
// ============================================================================
// divider_mse_monitor_if : sample/statistics bundle of the divider error monitor
// Optional feature macro: DIVIAC_REM_ERR_EN adds sum_sq_rerr.
// Revision: 1.0
// ============================================================================
interface divider_mse_monitor_if
    import divider_mon_pkg::*;
#(
    parameter int NW    = NW_D,
    parameter int DW    = DW_D,
    parameter int ACC_W = ACC_W_D,
    parameter int CNT_W = CNT_W_D
);
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [NW-1:0]    n;
    logic [DW-1:0]    d;
    logic [DW-1:0]    q_apx;
    logic [DW-1:0]    r_apx;
    logic             out_valid;
    logic [DW-1:0]    q_exact;
    logic [ACC_W-1:0] sum_sq_err;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] skip_count;
    logic [DW-1:0]    max_abs_err;
    logic             sat;
`ifdef DIVIAC_REM_ERR_EN
    logic [ACC_W-1:0] sum_sq_rerr;
`endif

    modport slave (
        input  clear, in_valid, n, d, q_apx, r_apx,
        output in_ready, out_valid, q_exact, sum_sq_err, sample_count, skip_count,
               max_abs_err, sat
`ifdef DIVIAC_REM_ERR_EN
        , output sum_sq_rerr
`endif
    );

    modport master (
        output clear, in_valid, n, d, q_apx, r_apx,
        input  in_ready, out_valid, q_exact, sum_sq_err, sample_count, skip_count,
               max_abs_err, sat
`ifdef DIVIAC_REM_ERR_EN
        , input sum_sq_rerr
`endif
    );
endinterface
`default_nettype wire

// File: rtl/divider_mse_monitor_div.sv
`default_nettype none
// ============================================================================
// restoring_div_seq : one-step-per-cycle restoring divider, MSB first
// Revision: 1.0
// ============================================================================
module restoring_div_seq
    import divider_mon_pkg::*;
#(
    parameter int NW = NW_D,
    parameter int DW = DW_D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          abort,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic [DW-1:0] d,
    output logic          done,
    output logic [DW-1:0] q_exact,
    output logic [DW-1:0] r_exact
);
    localparam int c_ITER_W = $clog2(DW + 1);

    logic [DW:0]         r_prem;
    logic [DW-1:0]       r_lo;
    logic [DW-1:0]       r_d;
    logic [DW-1:0]       r_q;
    logic [c_ITER_W-1:0] r_iter;
    logic                r_busy;

    logic [DW+1:0]       w_shift;
    logic [DW+1:0]       w_diff;
    logic                w_ge;

    // Start guarantees n[NW-1:DW] < d, so every partial remainder fits in DW bits.
    assign w_shift = {r_prem, r_lo[DW-1]};
    assign w_ge    = w_shift >= {2'b00, r_d};
    assign w_diff  = w_shift - {2'b00, r_d};

    assign done    = r_busy && (r_iter == '0);
    assign q_exact = r_q;
    assign r_exact = r_prem[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_prem <= '0;
            r_lo   <= '0;
            r_d    <= '0;
            r_q    <= '0;
            r_iter <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_prem <= {1'b0, n[NW-1:DW]};
            r_lo   <= n[DW-1:0];
            r_d    <= d;
            r_q    <= '0;
            r_iter <= c_ITER_W'(DW - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_prem <= w_ge ? (DW+1)'(w_diff) : (DW+1)'(w_shift);
            r_q    <= {r_q[DW-2:0], w_ge};
            r_lo   <= {r_lo[DW-2:0], 1'b0};
            r_iter <= r_iter - c_ITER_W'(1);
            if (r_iter == '0) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/divider_mse_monitor.sv
`default_nettype none
// ============================================================================
// divider_mse_monitor : exact-vs-approximate quotient error statistics
// Optional feature macro: DIVIAC_REM_ERR_EN accumulates squared remainder error.
// Revision: 1.0
// ============================================================================
module divider_mse_monitor
    import divider_mon_pkg::*;
#(
    parameter int NW    = NW_D,
    parameter int DW    = DW_D,
    parameter int ACC_W = ACC_W_D,
    parameter int CNT_W = CNT_W_D
) (
    input  logic                 clk,
    input  logic                 rst,
    divider_mse_monitor_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_q_apx;
    logic [DW-1:0]    r_q_exact;
    logic [DW-1:0]    r_max_abs_err;
    logic [ACC_W-1:0] r_sum_sq_err;
    logic [CNT_W-1:0] r_sample_count;
    logic [CNT_W-1:0] r_skip_count;
    logic             r_out_valid;
    logic             r_sat;

    logic             w_accept;
    logic             w_out_of_range;
    logic             w_div_done;
    logic [DW-1:0]    w_div_q;
    logic [DW:0]      w_err;
    logic [DW-1:0]    w_abs_err;
    logic [2*DW-1:0]  w_sq_err;
    logic             w_any_ovf;

    assign bus.in_ready = (r_state == ST_IDLE) && !bus.clear && !rst;
    assign w_accept       = bus.in_valid && bus.in_ready;
    assign w_out_of_range = (bus.d == '0) || (bus.n[NW-1:DW] >= bus.d);

`ifdef DIVIAC_REM_ERR_EN
    logic [DW-1:0]    w_div_r;
    logic [DW-1:0]    r_r_apx;
    logic [ACC_W-1:0] r_sum_sq_rerr;
    logic [DW:0]      w_rerr;
    logic [DW-1:0]    w_abs_rerr;
    logic [2*DW-1:0]  w_sq_rerr;

    assign w_rerr     = {1'b0, w_div_r} - {1'b0, r_r_apx};
    assign w_abs_rerr = DW'(w_rerr[DW] ? -w_rerr : w_rerr);
    assign w_sq_rerr  = {{DW{1'b0}}, w_abs_rerr} * {{DW{1'b0}}, w_abs_rerr};
    assign bus.sum_sq_rerr = r_sum_sq_rerr;
`endif

    restoring_div_seq #(
        .NW (NW),
        .DW (DW)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .abort   (bus.clear),
        .start   (w_accept && !w_out_of_range),
        .n       (bus.n),
        .d       (bus.d),
        .done    (w_div_done),
        .q_exact (w_div_q),
`ifdef DIVIAC_REM_ERR_EN
        .r_exact (w_div_r)
`else
        .r_exact ()
`endif
    );

    assign w_err     = {1'b0, w_div_q} - {1'b0, r_q_apx};
    assign w_abs_err = DW'(w_err[DW] ? -w_err : w_err);
    assign w_sq_err  = {{DW{1'b0}}, w_abs_err} * {{DW{1'b0}}, w_abs_err};

    assign w_any_ovf = sat_ovf(64'(r_sum_sq_err), 64'(w_sq_err), ACC_W)
                     | sat_ovf(64'(r_sample_count), 64'd1, CNT_W)
`ifdef DIVIAC_REM_ERR_EN
                     | sat_ovf(64'(r_sum_sq_rerr), 64'(w_sq_rerr), ACC_W)
`endif
                     ;

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_out_of_range ? ST_SKIP : ST_DIV;
            ST_DIV:  if (w_div_done) w_state_nxt = ST_ACC;
            ST_ACC:  w_state_nxt = ST_IDLE;
            ST_SKIP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_apx <= '0;
        end else if (w_accept) begin
            r_q_apx <= bus.q_apx;
        end
    end

`ifdef DIVIAC_REM_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r_apx <= '0;
        end else if (w_accept) begin
            r_r_apx <= bus.r_apx;
        end
    end
`endif

    // q_exact survives clear; only rst zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_exact <= '0;
        end else if (!bus.clear && r_state == ST_ACC) begin
            r_q_exact <= w_div_q;
        end else if (!bus.clear && r_state == ST_SKIP) begin
            r_q_exact <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_sum_sq_err   <= '0;
            r_sample_count <= '0;
            r_skip_count   <= '0;
            r_max_abs_err  <= '0;
            r_sat          <= 1'b0;
            r_out_valid    <= 1'b0;
`ifdef DIVIAC_REM_ERR_EN
            r_sum_sq_rerr  <= '0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_ACC: begin
                    r_sum_sq_err   <= ACC_W'(sat_add(64'(r_sum_sq_err), 64'(w_sq_err), ACC_W));
                    r_sample_count <= CNT_W'(sat_add(64'(r_sample_count), 64'd1, CNT_W));
                    if (w_abs_err > r_max_abs_err) begin
                        r_max_abs_err <= w_abs_err;
                    end
`ifdef DIVIAC_REM_ERR_EN
                    r_sum_sq_rerr  <= ACC_W'(sat_add(64'(r_sum_sq_rerr), 64'(w_sq_rerr), ACC_W));
`endif
                    r_sat       <= r_sat | w_any_ovf;
                    r_out_valid <= 1'b1;
                end
                ST_SKIP: begin
                    r_skip_count <= CNT_W'(sat_add(64'(r_skip_count), 64'd1, CNT_W));
                    r_sat        <= r_sat | sat_ovf(64'(r_skip_count), 64'd1, CNT_W);
                    r_out_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.q_exact      = r_q_exact;
    assign bus.sum_sq_err   = r_sum_sq_err;
    assign bus.sample_count = r_sample_count;
    assign bus.skip_count   = r_skip_count;
    assign bus.max_abs_err  = r_max_abs_err;
    assign bus.sat          = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_divider_mse_monitor.sv
`default_nettype none
// ============================================================================
// tb_divider_mse_monitor : scoreboard bench for divider_mse_monitor
// Optional feature macro: DIVIAC_REM_ERR_EN also checks sum_sq_rerr.
// Revision: 1.0
// ============================================================================
module tb_divider_mse_monitor;
    import divider_mon_pkg::*;

    typedef struct {
        logic [7:0]  q;
        logic [39:0] sum;
        logic [23:0] cnt;
        logic [23:0] skip;
        logic [7:0]  mx;
        logic        s;
        logic [39:0] rerr;
        int          exp_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divider_mse_monitor_if #(.NW(16), .DW(8), .ACC_W(40), .CNT_W(24)) bus ();
    divider_mse_monitor_if #(.NW(16), .DW(8), .ACC_W(8),  .CNT_W(24)) sbus ();

    divider_mse_monitor #(.NW(16), .DW(8), .ACC_W(40), .CNT_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow accumulator instance so saturation is reachable in a few samples.
    divider_mse_monitor #(.NW(16), .DW(8), .ACC_W(8), .CNT_W(24)) sdut (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input logic [7:0] q, input logic [39:0] sum,
                                input logic [23:0] cnt, input logic [23:0] skip,
                                input logic [7:0] mx, input logic s, input logic [39:0] rerr);
        exp_t e;
        e.q = q; e.sum = sum; e.cnt = cnt; e.skip = skip;
        e.mx = mx; e.s = s; e.rerr = rerr; e.exp_cyc = 0;
        return e;
    endfunction

    // Monitor: every out_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency",      64'(cyc),              64'(e.exp_cyc));
                chk("q_exact",      64'(bus.q_exact),      64'(e.q));
                chk("sum_sq_err",   64'(bus.sum_sq_err),   64'(e.sum));
                chk("sample_count", 64'(bus.sample_count), 64'(e.cnt));
                chk("skip_count",   64'(bus.skip_count),   64'(e.skip));
                chk("max_abs_err",  64'(bus.max_abs_err),  64'(e.mx));
                chk("sat",          64'(bus.sat),          64'(e.s));
`ifdef DIVIAC_REM_ERR_EN
                chk("sum_sq_rerr",  64'(bus.sum_sq_rerr),  64'(e.rerr));
`endif
            end
        end
    end

    // Handshake one sample; optionally push its expectation and check in_ready low time.
    task automatic hs(input logic [15:0] n, input logic [7:0] d, input logic [7:0] qa,
                      input logic [7:0] ra, input bit push, input exp_t e, input int lat);
        int waits = 0;
        int lows = 0;
        @(negedge clk);
        bus.n = n; bus.d = d; bus.q_apx = qa; bus.r_apx = ra; bus.in_valid = 1'b1;
        while (!bus.in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.in_ready) begin
            chk("handshake_timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (push) begin
            e.exp_cyc = cyc + lat;
            sb.push_back(e);
            @(negedge clk);
            while (!bus.in_ready && lows < 100) begin
                lows++;
                @(negedge clk);
            end
            chk("in_ready_low_cycles", 64'(lows), 64'(lat));
        end
    endtask

    task automatic ssend(input logic [7:0] qa, output bit got);
        int waits = 0;
        got = 1'b0;
        @(negedge clk);
        sbus.n = 16'd1000; sbus.d = 8'd10; sbus.q_apx = qa; sbus.r_apx = 8'd0;
        sbus.in_valid = 1'b1;
        while (!sbus.in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1;
        sbus.in_valid = 1'b0;
        waits = 0;
        while (waits < 30 && !got) begin
            @(negedge clk);
            if (sbus.out_valid) got = 1'b1;
            waits++;
        end
    endtask

    task automatic chk_stats_zero(input string tag);
        chk({tag, "_sum"},  64'(bus.sum_sq_err),   64'd0);
        chk({tag, "_cnt"},  64'(bus.sample_count), 64'd0);
        chk({tag, "_skip"}, 64'(bus.skip_count),   64'd0);
        chk({tag, "_max"},  64'(bus.max_abs_err),  64'd0);
        chk({tag, "_sat"},  64'(bus.sat),          64'd0);
    endtask

    initial begin
        bit   got;
        int   waits;
        exp_t dummy;
        dummy = mk(0, 0, 0, 0, 0, 0, 0);
        bus.clear = 0; bus.in_valid = 0; bus.n = 0; bus.d = 0; bus.q_apx = 0; bus.r_apx = 0;
        sbus.clear = 0; sbus.in_valid = 0; sbus.n = 0; sbus.d = 0; sbus.q_apx = 0; sbus.r_apx = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready",  64'(bus.in_ready),  64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_q_exact",   64'(bus.q_exact),   64'd0);
        chk_stats_zero("reset");

        // n, d, q_apx, r_apx, expected {q, sum, cnt, skip, max, sat, rerr}, latency
        hs(16'd1000,   8'd10,  8'd98,  8'd0,   1, mk(100, 4,     1, 0, 2,   0, 0), 9);
        hs(16'h0A00,   8'd10,  8'd0,   8'd0,   1, mk(0,   4,     1, 1, 2,   0, 0), 1);
        hs(16'd1234,   8'd0,   8'd0,   8'd0,   1, mk(0,   4,     1, 2, 2,   0, 0), 1);
        hs(16'd255,    8'd3,   8'd85,  8'd0,   1, mk(85,  4,     2, 2, 2,   0, 0), 9);
        hs(16'd500,    8'd7,   8'd70,  8'd3,   1, mk(71,  5,     3, 2, 2,   0, 0), 9);
        hs(16'd65000,  8'd255, 8'd252, 8'd230, 1, mk(254, 9,     4, 2, 2,   0, 0), 9);
        hs(16'd1003,   8'd10,  8'd100, 8'd0,   1, mk(100, 9,     5, 2, 2,   0, 9), 9);
        hs(16'hFEFF,   8'd255, 8'd0,   8'd254, 1, mk(255, 65034, 6, 2, 255, 0, 9), 9);
        hs(16'd5,      8'd7,   8'd3,   8'd5,   1, mk(0,   65043, 7, 2, 255, 0, 9), 9);
        hs(16'hFFFF,   8'd255, 8'd0,   8'd0,   1, mk(0,   65043, 7, 3, 255, 0, 9), 1);

        waits = 0;
        while (sb.size() != 0 && waits < 100) begin
            @(negedge clk);
            waits++;
        end

        // Clear together with in_valid: nothing accepted, statistics zeroed.
        @(negedge clk);
        bus.n = 16'd1000; bus.d = 8'd10; bus.q_apx = 8'd0; bus.in_valid = 1'b1; bus.clear = 1'b1;
        #1;
        chk("in_ready_during_clear", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk_stats_zero("after_clear");
        repeat (12) @(negedge clk);
        chk("clear_valid_no_sample", 64'(bus.sample_count), 64'd0);

        // Clear while dividing: the sample is dropped without out_valid.
        hs(16'd1000, 8'd10, 8'd0, 8'd0, 0, dummy, 9);
        repeat (3) @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        repeat (15) @(negedge clk);
        chk_stats_zero("abort");
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);

        hs(16'd1000, 8'd10, 8'd100, 8'd0, 1, mk(100, 0, 1, 0, 0, 0, 0), 9);

        // Saturation on the 8-bit accumulator instance.
        ssend(8'd90, got);
        chk("s1_out_valid", 64'(got), 64'd1);
        chk("s1_sum", 64'(sbus.sum_sq_err), 64'd100);
        chk("s1_sat", 64'(sbus.sat), 64'd0);
        ssend(8'd84, got);
        chk("s2_out_valid", 64'(got), 64'd1);
        chk("s2_sum", 64'(sbus.sum_sq_err), 64'd255);
        chk("s2_sat", 64'(sbus.sat), 64'd1);
        chk("s2_cnt", 64'(sbus.sample_count), 64'd2);
        chk("s2_max", 64'(sbus.max_abs_err), 64'd16);
        @(negedge clk);
        sbus.clear = 1'b1;
        @(posedge clk);
        #1;
        sbus.clear = 1'b0;
        @(negedge clk);
        chk("s_clear_sum", 64'(sbus.sum_sq_err), 64'd0);
        chk("s_clear_sat", 64'(sbus.sat), 64'd0);
        chk("s_clear_cnt", 64'(sbus.sample_count), 64'd0);

        waits = 0;
        while (sb.size() != 0 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
